// File: rtl/ptw_arbiter.sv
// ptw_arbiter
//    Shares one page-table walker between the ITLB and the DTLB. A miss is
//    granted from IDLE and its address and attributes are registered. The
//    request is presented to the walker in REQ and the walk is tracked in
//    WALK. The result is then routed back to the requesting TLB as a
//    one-cycle update or fault pulse. The DTLB normally wins arbitration,
//    but a starvation counter hands the walker to a waiting ITLB after
//    STARVE_LIMIT consecutive DTLB grants. A flush drops or drains any
//    outstanding walk and is acknowledged with a single flush_ack_o pulse.
//
// Ports
//    clk_i, rst_i            clock, synchronous active-high reset
//    flush_i                 SFENCE/flush pulse
//    itlb_miss_i/vaddr_i     ITLB miss request (level) and address
//    dtlb_miss_i/vaddr_i     DTLB miss request (level) and address
//    dtlb_is_store_i         DTLB miss is caused by a store
//    ptw_req_*_o             walk request to the PTW, ptw_req_ready_i accepts
//    ptw_done_i/error_i      walk completion pulse and fault qualifier
//    itlb/dtlb_update_en_o   one-cycle refill strobes
//    itlb/dtlb_fault_o       one-cycle walk fault strobes
//    busy_o                  arbiter is not idle
//    flush_ack_o             flush complete, one-cycle pulse
module ptw_arbiter #(
   parameter int VLEN         = 39,
   parameter int STARVE_LIMIT = 4
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            flush_i,
   input  logic            itlb_miss_i,
   input  logic [VLEN-1:0] itlb_vaddr_i,
   input  logic            dtlb_miss_i,
   input  logic [VLEN-1:0] dtlb_vaddr_i,
   input  logic            dtlb_is_store_i,
   output logic            ptw_req_valid_o,
   input  logic            ptw_req_ready_i,
   output logic [VLEN-1:0] ptw_req_vaddr_o,
   output logic            ptw_req_is_instr_o,
   output logic            ptw_req_is_store_o,
   input  logic            ptw_done_i,
   input  logic            ptw_error_i,
   output logic            itlb_update_en_o,
   output logic            dtlb_update_en_o,
   output logic            itlb_fault_o,
   output logic            dtlb_fault_o,
   output logic            busy_o,
   output logic            flush_ack_o
);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WALK,
      DRAIN
   } state_e;

   localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

   state_e          state_q, state_d;
   logic [3:0]      starveCnt_q, starveCnt_d;
   logic [VLEN-1:0] vaddr_q, vaddr_d;
   logic            isInstr_q, isInstr_d;
   logic            isStore_q, isStore_d;
   logic            iUpd_q, iUpd_d;
   logic            dUpd_q, dUpd_d;
   logic            iFault_q, iFault_d;
   logic            dFault_q, dFault_d;
   logic            flushAck_q, flushAck_d;
   logic            grantInstr;

   // The ITLB only wins when it is the sole requester or when the DTLB has
   // already been granted STARVE_LIMIT times in a row while the ITLB waited.
   assign grantInstr = itlb_miss_i && (!dtlb_miss_i || (starveCnt_q == StarveMax));

   // Next-state and result logic. Result and flush-ack strobes are computed
   // here and registered, so they appear in the cycle the FSM is back in
   // IDLE and can never overlap ptw_req_valid_o.
   always_comb begin
      state_d     = state_q;
      starveCnt_d = starveCnt_q;
      vaddr_d     = vaddr_q;
      isInstr_d   = isInstr_q;
      isStore_d   = isStore_q;
      iUpd_d      = 1'b0;
      dUpd_d      = 1'b0;
      iFault_d    = 1'b0;
      dFault_d    = 1'b0;
      flushAck_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (flush_i) begin
               flushAck_d = 1'b1;
            end else if (itlb_miss_i || dtlb_miss_i) begin
               state_d   = REQ;
               vaddr_d   = grantInstr ? itlb_vaddr_i : dtlb_vaddr_i;
               isInstr_d = grantInstr;
               isStore_d = !grantInstr && dtlb_is_store_i;
               if (grantInstr) begin
                  starveCnt_d = 4'd0;
               end else if (itlb_miss_i && (starveCnt_q < StarveMax)) begin
                  starveCnt_d = starveCnt_q + 4'd1;
               end
            end
         end
         REQ: begin
            // Once the walker has accepted the request, its completion
            // still has to be waited for, hence DRAIN instead of IDLE.
            if (flush_i) begin
               if (ptw_req_ready_i) begin
                  state_d = DRAIN;
               end else begin
                  state_d    = IDLE;
                  flushAck_d = 1'b1;
               end
            end else if (ptw_req_ready_i) begin
               state_d = WALK;
            end
         end
         WALK: begin
            if (ptw_done_i) begin
               state_d = IDLE;
               if (flush_i) begin
                  flushAck_d = 1'b1;
               end else begin
                  iUpd_d   = isInstr_q  && !ptw_error_i;
                  dUpd_d   = !isInstr_q && !ptw_error_i;
                  iFault_d = isInstr_q  && ptw_error_i;
                  dFault_d = !isInstr_q && ptw_error_i;
               end
            end else if (flush_i) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            // Further flushes are absorbed; the single ack follows the
            // completion of the discarded walk.
            if (ptw_done_i) begin
               state_d    = IDLE;
               flushAck_d = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and request registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         starveCnt_q <= 4'd0;
         vaddr_q     <= '0;
         isInstr_q   <= 1'b0;
         isStore_q   <= 1'b0;
         iUpd_q      <= 1'b0;
         dUpd_q      <= 1'b0;
         iFault_q    <= 1'b0;
         dFault_q    <= 1'b0;
         flushAck_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         starveCnt_q <= starveCnt_d;
         vaddr_q     <= vaddr_d;
         isInstr_q   <= isInstr_d;
         isStore_q   <= isStore_d;
         iUpd_q      <= iUpd_d;
         dUpd_q      <= dUpd_d;
         iFault_q    <= iFault_d;
         dFault_q    <= dFault_d;
         flushAck_q  <= flushAck_d;
      end
   end

   // Control outputs are masked by rst_i so they read 0 throughout reset,
   // including the first reset cycle before any clock edge has been seen.
   assign ptw_req_valid_o    = !rst_i && (state_q == REQ);
   assign ptw_req_vaddr_o    = vaddr_q;
   assign ptw_req_is_instr_o = isInstr_q;
   assign ptw_req_is_store_o = isStore_q;
   assign itlb_update_en_o   = !rst_i && iUpd_q;
   assign dtlb_update_en_o   = !rst_i && dUpd_q;
   assign itlb_fault_o       = !rst_i && iFault_q;
   assign dtlb_fault_o       = !rst_i && dFault_q;
   assign busy_o             = !rst_i && (state_q != IDLE);
   assign flush_ack_o        = !rst_i && flushAck_q;

endmodule

// File: tb/tb_ptw_arbiter.sv
// tb_ptw_arbiter
//    Cycle-by-cycle vector bench for ptw_arbiter. Each record holds the
//    inputs for one clock cycle and the outputs expected right after that
//    clock edge. Expected records go into a scoreboard queue as the
//    stimulus is driven and are popped when the outputs are sampled.
module tb_ptw_arbiter;

   localparam int VLEN = 39;
   localparam logic [VLEN-1:0] IVA = 39'h12_3456_7000;
   localparam logic [VLEN-1:0] DVA = 39'h7f_0000_a000;

   // in : {rst, flush, imiss, dmiss, dstore, ready, done, err}
   // ex : {valid, isInstr, isStore, iUpd, dUpd, iFault, dFault, busy, flushAck}
   typedef struct {
      string           name;
      logic [7:0]      in;
      logic [8:0]      ex;
      logic [VLEN-1:0] eva;
   } vec_t;

   logic            clk;
   logic            rst_i, flush_i, itlb_miss_i, dtlb_miss_i, dtlb_is_store_i;
   logic [VLEN-1:0] itlb_vaddr_i, dtlb_vaddr_i;
   logic            ptw_req_valid_o, ptw_req_ready_i;
   logic [VLEN-1:0] ptw_req_vaddr_o;
   logic            ptw_req_is_instr_o, ptw_req_is_store_o;
   logic            ptw_done_i, ptw_error_i;
   logic            itlb_update_en_o, dtlb_update_en_o, itlb_fault_o, dtlb_fault_o;
   logic            busy_o, flush_ack_o;

   vec_t vecs[$];
   vec_t expQ[$];
   int   nApplied = 0;
   int   nMiss    = 0;

   ptw_arbiter #(.VLEN(VLEN), .STARVE_LIMIT(4)) dut (
      .clk_i             (clk),
      .rst_i             (rst_i),
      .flush_i           (flush_i),
      .itlb_miss_i       (itlb_miss_i),
      .itlb_vaddr_i      (itlb_vaddr_i),
      .dtlb_miss_i       (dtlb_miss_i),
      .dtlb_vaddr_i      (dtlb_vaddr_i),
      .dtlb_is_store_i   (dtlb_is_store_i),
      .ptw_req_valid_o   (ptw_req_valid_o),
      .ptw_req_ready_i   (ptw_req_ready_i),
      .ptw_req_vaddr_o   (ptw_req_vaddr_o),
      .ptw_req_is_instr_o(ptw_req_is_instr_o),
      .ptw_req_is_store_o(ptw_req_is_store_o),
      .ptw_done_i        (ptw_done_i),
      .ptw_error_i       (ptw_error_i),
      .itlb_update_en_o  (itlb_update_en_o),
      .dtlb_update_en_o  (dtlb_update_en_o),
      .itlb_fault_o      (itlb_fault_o),
      .dtlb_fault_o      (dtlb_fault_o),
      .busy_o            (busy_o),
      .flush_ack_o       (flush_ack_o)
   );

   // Free-running clock, period 10.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input string n, input logic [7:0] in,
                               input logic [8:0] ex, input logic [VLEN-1:0] eva);
      vec_t v;
      v.name = n;
      v.in   = in;
      v.ex   = ex;
      v.eva  = eva;
      return v;
   endfunction

   // Drives one cycle of inputs while the clock is low and queues its
   // expected outputs.
   task automatic applyStimulus(input vec_t v);
      @(negedge clk);
      rst_i           = v.in[7];
      flush_i         = v.in[6];
      itlb_miss_i     = v.in[5];
      dtlb_miss_i     = v.in[4];
      dtlb_is_store_i = v.in[3];
      ptw_req_ready_i = v.in[2];
      ptw_done_i      = v.in[1];
      ptw_error_i     = v.in[0];
      expQ.push_back(v);
      nApplied++;
   endtask

   // Samples the outputs 1 time unit after the rising edge. The request
   // attributes and address are only meaningful while a request is
   // expected to be valid, so they are masked otherwise.
   task automatic checkOutput();
      vec_t       e;
      logic [8:0] act;
      logic [8:0] mask;
      logic       bad;
      @(posedge clk);
      #1;
      e    = expQ.pop_front();
      act  = {ptw_req_valid_o, ptw_req_is_instr_o, ptw_req_is_store_o,
              itlb_update_en_o, dtlb_update_en_o, itlb_fault_o, dtlb_fault_o,
              busy_o, flush_ack_o};
      mask = e.ex[8] ? 9'h1FF : 9'h13F;
      bad  = ((act & mask) !== (e.ex & mask)) ||
             (e.ex[8] && (ptw_req_vaddr_o !== e.eva));
      if (bad) begin
         nMiss++;
         $display("[TB] FAIL %s: got flags=%b vaddr=%h, want flags=%b vaddr=%h",
                  e.name, act, ptw_req_vaddr_o, e.ex, e.eva);
      end
   endtask

   initial begin
      rst_i           = 1'b1;
      flush_i         = 1'b0;
      itlb_miss_i     = 1'b0;
      dtlb_miss_i     = 1'b0;
      dtlb_is_store_i = 1'b0;
      ptw_req_ready_i = 1'b0;
      ptw_done_i      = 1'b0;
      ptw_error_i     = 1'b0;
      itlb_vaddr_i    = IVA;
      dtlb_vaddr_i    = DVA;

      // Reset, then simultaneous misses: DTLB (store) first, then ITLB with a fault.
      vecs.push_back(mk("rst0",         8'b1011_0000, 9'b000000000, '0));
      vecs.push_back(mk("rst1",         8'b1011_0000, 9'b000000000, '0));
      vecs.push_back(mk("grantD",       8'b0011_1000, 9'b101000010, DVA));
      vecs.push_back(mk("reqD",         8'b0011_1100, 9'b000000010, '0));
      vecs.push_back(mk("walkD1",       8'b0011_0000, 9'b000000010, '0));
      vecs.push_back(mk("walkD2",       8'b0011_0000, 9'b000000010, '0));
      vecs.push_back(mk("doneD",        8'b0011_0010, 9'b000010000, '0));
      vecs.push_back(mk("grantI",       8'b0010_0000, 9'b110000010, IVA));
      vecs.push_back(mk("reqI",         8'b0010_0100, 9'b000000010, '0));
      vecs.push_back(mk("faultI",       8'b0010_0011, 9'b000001000, '0));
      vecs.push_back(mk("idle",         8'b0000_0000, 9'b000000000, '0));
      vecs.push_back(mk("doneInIdle",   8'b0000_0010, 9'b000000000, '0));
      // Flush in IDLE, done ignored in REQ, flush in REQ without ready.
      vecs.push_back(mk("flushIdle",    8'b0101_0000, 9'b000000001, '0));
      vecs.push_back(mk("grantD2",      8'b0001_0000, 9'b100000010, DVA));
      vecs.push_back(mk("doneInReq",    8'b0001_0010, 9'b100000010, DVA));
      vecs.push_back(mk("flushReq",     8'b0101_0000, 9'b000000001, '0));
      vecs.push_back(mk("regrant",      8'b0001_0000, 9'b100000010, DVA));
      // Flush in WALK, then done 5 cycles later from DRAIN.
      vecs.push_back(mk("toWalk",       8'b0001_0100, 9'b000000010, '0));
      vecs.push_back(mk("flushWalk",    8'b0101_0000, 9'b000000010, '0));
      vecs.push_back(mk("drain1",       8'b0001_0000, 9'b000000010, '0));
      vecs.push_back(mk("drainFlush",   8'b0101_0000, 9'b000000010, '0));
      vecs.push_back(mk("drain3",       8'b0001_0000, 9'b000000010, '0));
      vecs.push_back(mk("drain4",       8'b0001_0000, 9'b000000010, '0));
      vecs.push_back(mk("drainDone",    8'b0001_0010, 9'b000000001, '0));
      vecs.push_back(mk("afterDrain",   8'b0000_0000, 9'b000000000, '0));
      // Flush in REQ with ready, and flush together with done in WALK.
      vecs.push_back(mk("grantI2",      8'b0010_0000, 9'b110000010, IVA));
      vecs.push_back(mk("flushReqRdy",  8'b0110_0100, 9'b000000010, '0));
      vecs.push_back(mk("drainDone2",   8'b0010_0010, 9'b000000001, '0));
      vecs.push_back(mk("grantI3",      8'b0010_0000, 9'b110000010, IVA));
      vecs.push_back(mk("walkI3",       8'b0010_0100, 9'b000000010, '0));
      vecs.push_back(mk("flushDone",    8'b0110_0010, 9'b000000001, '0));
      vecs.push_back(mk("quiet",        8'b0000_0000, 9'b000000000, '0));
      // Reset in the middle of a walk, then a stray done.
      vecs.push_back(mk("grantD3",      8'b0001_0000, 9'b100000010, DVA));
      vecs.push_back(mk("walkD3",       8'b0001_0100, 9'b000000010, '0));
      vecs.push_back(mk("rstInWalk",    8'b1001_0000, 9'b000000000, '0));
      vecs.push_back(mk("strayDone",    8'b0000_0010, 9'b000000000, '0));
      vecs.push_back(mk("quiet2",       8'b0000_0000, 9'b000000000, '0));

      // Starvation: both misses held, four DTLB walks, then the ITLB wins.
      for (int k = 0; k < 4; k++) begin
         vecs.push_back(mk($sformatf("stvGrantD%0d", k), 8'b0011_0000, 9'b100000010, DVA));
         vecs.push_back(mk($sformatf("stvReady%0d", k),  8'b0011_0100, 9'b000000010, '0));
         vecs.push_back(mk($sformatf("stvDone%0d", k),   8'b0011_0010, 9'b000010000, '0));
      end
      vecs.push_back(mk("stvGrantI",    8'b0011_0000, 9'b110000010, IVA));
      vecs.push_back(mk("stvReadyI",    8'b0011_0100, 9'b000000010, '0));
      vecs.push_back(mk("stvDoneI",     8'b0011_0010, 9'b000100000, '0));
      // Counter cleared by the ITLB grant: the DTLB wins again.
      vecs.push_back(mk("stvCntClear",  8'b0011_0000, 9'b100000010, DVA));
      vecs.push_back(mk("stvReadyD",    8'b0001_0100, 9'b000000010, '0));
      vecs.push_back(mk("stvFaultD",    8'b0001_0011, 9'b000000100, '0));
      vecs.push_back(mk("end",          8'b0000_0000, 9'b000000000, '0));

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i]);
         checkOutput();
      end

      $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiss);
      $finish;
   end

endmodule

// File: doc/ptw_arbiter.md
PTW_ARBITER -- requirements
Module: ptw_arbiter

Interface
REQ-001 SHALL have parameter VLEN, default 39, virtual address width.
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, the number of consecutive DTLB grants allowed while ITLB waits (1..15).
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_i, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port flush_i, input, 1, SFENCE/flush pulse.
REQ-006 SHALL have port itlb_miss_i, input, 1, ITLB miss request, level, held until served.
REQ-007 SHALL have port itlb_vaddr_i, input, VLEN, ITLB miss address.
REQ-008 SHALL have port dtlb_miss_i, input, 1, DTLB miss request, level, held until served.
REQ-009 SHALL have port dtlb_vaddr_i, input, VLEN, DTLB miss address.
REQ-010 SHALL have port dtlb_is_store_i, input, 1, DTLB miss is a store.
REQ-011 SHALL have port ptw_req_valid_o, output, 1, walk request to the page-table walker (PTW).
REQ-012 SHALL have port ptw_req_ready_i, input, 1, PTW accepts the request.
REQ-013 SHALL have port ptw_req_vaddr_o, output, VLEN, registered walk address.
REQ-014 SHALL have port ptw_req_is_instr_o, output, 1, walk is for the ITLB.
REQ-015 SHALL have port ptw_req_is_store_o, output, 1, walk is a store (always 0 for ITLB).
REQ-016 SHALL have port ptw_done_i, input, 1, one-cycle walk completion pulse.
REQ-017 SHALL have port ptw_error_i, input, 1, walk faulted; qualified by ptw_done_i.
REQ-018 SHALL have port itlb_update_en_o, output, 1, write PTW result into ITLB, one cycle.
REQ-019 SHALL have port dtlb_update_en_o, output, 1, write PTW result into DTLB, one cycle.
REQ-020 SHALL have port itlb_fault_o, output, 1, ITLB walk fault, one cycle.
REQ-021 SHALL have port dtlb_fault_o, output, 1, DTLB walk fault, one cycle.
REQ-022 SHALL have port busy_o, output, 1, state is not IDLE.
REQ-023 SHALL have port flush_ack_o, output, 1, flush complete, one-cycle pulse.

Function
REQ-024 SHALL implement FSM states IDLE, REQ, WALK and DRAIN.
REQ-025 In IDLE with no flush_i and at least one miss, SHALL grant one requester, register vaddr, is_instr and is_store, and go to REQ next cycle.
REQ-026 Arbitration SHALL give DTLB priority, except that ITLB wins when starve_cnt == STARVE_LIMIT.
REQ-027 starve_cnt SHALL be 4 bits; it increments on a DTLB grant while itlb_miss_i is high, saturates at STARVE_LIMIT, and clears on an ITLB grant.
REQ-028 ptw_req_valid_o SHALL be 1 only in REQ; ptw_req_vaddr_o, ptw_req_is_instr_o and ptw_req_is_store_o SHALL stay stable while in REQ.
REQ-029 In REQ with ptw_req_ready_i=1, SHALL go to WALK.
REQ-030 In WALK with ptw_done_i=1, SHALL pulse exactly one of the four result outputs next cycle, selected by the registered is_instr and by ptw_error_i (error means fault, otherwise update_en), then go to IDLE.
REQ-031 A result pulse SHALL never coincide with ptw_req_valid_o; a new grant is possible at the earliest in the cycle the result pulse is driven (IDLE).
REQ-032 flush_i in IDLE: SHALL make no grant that cycle and pulse flush_ack_o next cycle.
REQ-033 flush_i in REQ with ptw_req_ready_i=0: SHALL drop the request, return to IDLE and pulse flush_ack_o next cycle.
REQ-034 flush_i in REQ with ptw_req_ready_i=1: SHALL go to DRAIN.
REQ-035 flush_i in WALK without ptw_done_i: SHALL go to DRAIN.
REQ-036 flush_i in WALK together with ptw_done_i: SHALL discard the result and pulse flush_ack_o next cycle.
REQ-037 In DRAIN with ptw_done_i=1, SHALL discard the result (no update or fault pulse), pulse flush_ack_o next cycle and go to IDLE.
REQ-038 flush_i in DRAIN SHALL be absorbed and yield a single flush_ack_o.
REQ-039 flush_i SHALL not clear starve_cnt.
REQ-040 A ptw_done_i in IDLE or REQ SHALL be ignored.
REQ-041 Misses deasserted before grant SHALL be ignored; a request that is not re-asserted is not remembered.

Reset
REQ-042 rst_i=1 at a clock edge SHALL force IDLE, starve_cnt=0 and all registered request fields to 0.
REQ-043 During reset, all outputs SHALL be 0: ptw_req_valid_o, all update and fault enables, busy_o and flush_ack_o.
REQ-044 Reset mid-walk SHALL drop the walk silently: no flush_ack_o, and a later ptw_done_i is ignored per REQ-040.

Verification
REQ-045 Simultaneous misses: dtlb_miss_i=itlb_miss_i=1, ready=1, done 3 cycles later, error=0 -> DTLB walk first, dtlb_update_en_o pulses once, then ITLB granted from IDLE.
REQ-046 Starvation: both misses held, STARVE_LIMIT=4 -> 4 DTLB walks, then the 5th grant has is_instr=1 and starve_cnt returns to 0.
REQ-047 Fault routing: ITLB miss, ptw_done_i=1 with ptw_error_i=1 -> itlb_fault_o for 1 cycle and itlb_update_en_o stays 0.
REQ-048 Flush during WALK: flush_i pulse, then ptw_done_i 5 cycles later -> no update or fault pulse, flush_ack_o exactly once the cycle after done, and busy_o=0 after that.
REQ-049 Flush in REQ with ready=0 -> ptw_req_valid_o=0 and flush_ack_o=1 next cycle; a held miss is re-granted the cycle after.
REQ-050 Reset asserted in WALK, then ptw_done_i -> all outputs 0 and no update pulse.
